// File: rtl/display_scan_controller.sv
// Scans the shared 4-digit display. The source is arbitrated and its digits are
// snapshotted once per frame, so a frame never mixes two sources or two times.
module display_scan_controller #(
    parameter int SCAN_DIV  = 4,
    parameter int BLINK_DIV = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       normal_mode_en,
    input  logic       setting_mode_en,
    input  logic       alarm_mode_en,
    input  logic       stopwatch_mode_en,
    input  logic [1:0] tens_hours,
    input  logic [3:0] units_hours,
    input  logic [2:0] tens_minutes,
    input  logic [3:0] units_minutes,
    input  logic       alarm_sound,
    input  logic [5:0] sw_min,
    input  logic [5:0] sw_sec,
    output logic [3:0] digit_sel,
    output logic [3:0] digit_bcd,
    output logic       colon,
    output logic [1:0] source
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(SCAN_DIV - 1);
    localparam logic [FW-1:0] FR_LAST = FW'(BLINK_DIV - 1);

    localparam logic [1:0] SRC_NORMAL = 2'b00;
    localparam logic [1:0] SRC_SET    = 2'b01;
    localparam logic [1:0] SRC_ALARM  = 2'b10;
    localparam logic [1:0] SRC_SW     = 2'b11;

    logic [PW-1:0]    presc;
    logic [1:0]       idx, idx_nxt;
    logic [FW-1:0]    frame_cnt;
    logic             blink, blink_nxt, blink_use;
    logic             alarm_cap, alarm_use;
    logic [1:0]       src, src_sel, src_use;
    logic [3:0][3:0]  snap, snap_new, snap_use, clk_dig, sw_dig;
    logic             tc, fs, blank;

    // Binary 0-63 to two BCD digits; 60-63 saturate to 59.
    function automatic logic [7:0] bin2bcd(input logic [5:0] v);
        logic [5:0] s, t, u;
        s = (v > 6'd59) ? 6'd59 : v;
        t = s / 6'd10;
        u = s % 6'd10;
        return {t[3:0], u[3:0]};
    endfunction

    always_comb begin
        tc      = (presc == PS_LAST);
        fs      = tc && (idx == 2'd3);
        idx_nxt = idx + 2'd1;

        src_sel = src;
        if (stopwatch_mode_en)    src_sel = SRC_SW;
        else if (setting_mode_en) src_sel = SRC_SET;
        else if (alarm_mode_en)   src_sel = SRC_ALARM;
        else if (normal_mode_en)  src_sel = SRC_NORMAL;

        clk_dig[0] = {2'b00, tens_hours};
        clk_dig[1] = units_hours;
        clk_dig[2] = {1'b0, tens_minutes};
        clk_dig[3] = units_minutes;
        {sw_dig[0], sw_dig[1]} = bin2bcd(sw_min);
        {sw_dig[2], sw_dig[3]} = bin2bcd(sw_sec);
        snap_new  = (src_sel == SRC_SW) ? sw_dig : clk_dig;
        blink_nxt = (frame_cnt == FR_LAST) ? ~blink : blink;

        // Outputs on a frame-start edge must reflect the state being captured.
        src_use   = fs ? src_sel     : src;
        snap_use  = fs ? snap_new    : snap;
        blink_use = fs ? blink_nxt   : blink;
        alarm_use = fs ? alarm_sound : alarm_cap;
        blank     = blink_use && ((src_use == SRC_SET) || (src_use == SRC_ALARM) ||
                                  ((src_use == SRC_NORMAL) && alarm_use));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc     <= PS_LAST;
            idx       <= 2'd3;
            frame_cnt <= '0;
            blink     <= 1'b0;
            alarm_cap <= 1'b0;
            src       <= SRC_NORMAL;
            snap      <= '0;
            digit_sel <= 4'b0000;
            digit_bcd <= 4'd0;
            colon     <= 1'b0;
        end else begin
            presc <= tc ? '0 : presc + PW'(1);
            if (fs) begin
                src       <= src_sel;
                snap      <= snap_new;
                alarm_cap <= alarm_sound;
                frame_cnt <= (frame_cnt == FR_LAST) ? '0 : frame_cnt + FW'(1);
                blink     <= blink_nxt;
            end
            if (tc) begin
                idx       <= idx_nxt;
                digit_sel <= blank ? 4'b0000 : (4'b1000 >> idx_nxt);
                digit_bcd <= snap_use[idx_nxt];
                colon     <= blank ? 1'b0 : ((src_use == SRC_NORMAL) ? ~blink_use : 1'b1);
            end
        end
    end

    assign source = src;

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench for display_scan_controller with SCAN_DIV=4, BLINK_DIV=2
// (a slot is 4 cycles, a frame 16 cycles, blink phase flips every 2 frames).
module tb_display_scan_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       normal_mode_en, setting_mode_en, alarm_mode_en, stopwatch_mode_en;
    logic [1:0] tens_hours;
    logic [3:0] units_hours;
    logic [2:0] tens_minutes;
    logic [3:0] units_minutes;
    logic       alarm_sound;
    logic [5:0] sw_min, sw_sec;
    logic [3:0] digit_sel, digit_bcd;
    logic       colon;
    logic [1:0] source;

    int vec  = 0;
    int errs = 0;

    display_scan_controller #(.SCAN_DIV(4), .BLINK_DIV(2)) dut (
        .clk(clk), .rst(rst),
        .normal_mode_en(normal_mode_en), .setting_mode_en(setting_mode_en),
        .alarm_mode_en(alarm_mode_en), .stopwatch_mode_en(stopwatch_mode_en),
        .tens_hours(tens_hours), .units_hours(units_hours),
        .tens_minutes(tens_minutes), .units_minutes(units_minutes),
        .alarm_sound(alarm_sound), .sw_min(sw_min), .sw_sec(sw_sec),
        .digit_sel(digit_sel), .digit_bcd(digit_bcd), .colon(colon), .source(source)
    );

    always #5 clk = ~clk;

    logic [10:0] obs;
    assign obs = {digit_sel, digit_bcd, colon, source};

    function automatic logic [10:0] ev(input logic [3:0] sel, input logic [3:0] bcd,
                                       input logic col, input logic [1:0] src);
        return {sel, bcd, col, src};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_time(input logic [1:0] th, input logic [3:0] uh,
                            input logic [2:0] tm, input logic [3:0] um);
        tens_hours = th; units_hours = uh; tens_minutes = tm; units_minutes = um;
    endtask

    task automatic test_reset;
        logic [10:0] e;
        rst = 1'b0;
        normal_mode_en = 1'b1; setting_mode_en = 1'b0;
        alarm_mode_en = 1'b0; stopwatch_mode_en = 1'b0;
        set_time(2'd1, 4'd2, 3'd3, 4'd4);
        alarm_sound = 1'b0; sw_min = 6'd7; sw_sec = 6'd45;
        tick(2);
        e = ev(4'b0000, 4'd0, 1'b0, 2'b00);
        vec++;
        if (obs !== e) begin errs++; $display("FAIL reset: got %h want %h", obs, e); end
    endtask

    // Frame 0 (blink 0) then the start of frame 1 (blink 1, colon off).
    task automatic test_normal;
        logic [10:0] e [6];
        int          dt [6];
        e  = '{ev(4'b1000,4'd1,1,0), ev(4'b1000,4'd1,1,0), ev(4'b0100,4'd2,1,0),
               ev(4'b0010,4'd3,1,0), ev(4'b0001,4'd4,1,0), ev(4'b1000,4'd1,0,0)};
        dt = '{1, 3, 1, 4, 4, 4};
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(dt[i]);
            vec++;
            if (obs !== e[i]) begin errs++; $display("FAIL normal[%0d]: got %h want %h", i, obs, e[i]); end
        end
    endtask

    // Stopwatch raised mid-slot idx=1 of frame 1; frame 2 shows 07:45.
    task automatic test_stopwatch;
        logic [10:0] e [6];
        int          dt [6];
        e  = '{ev(4'b0010,4'd3,0,0), ev(4'b0001,4'd4,0,0), ev(4'b1000,4'd0,1,3),
               ev(4'b0100,4'd7,1,3), ev(4'b0010,4'd4,1,3), ev(4'b0001,4'd5,1,3)};
        dt = '{3, 4, 4, 4, 4, 4};
        tick(5);
        stopwatch_mode_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(dt[i]);
            vec++;
            if (obs !== e[i]) begin errs++; $display("FAIL stopwatch[%0d]: got %h want %h", i, obs, e[i]); end
        end
    endtask

    // 63 min / 62 sec saturate to 59:59 in frame 3.
    task automatic test_saturate;
        logic [10:0] e [4];
        e = '{ev(4'b1000,4'd5,1,3), ev(4'b0100,4'd9,1,3),
              ev(4'b0010,4'd5,1,3), ev(4'b0001,4'd9,1,3)};
        sw_min = 6'd63; sw_sec = 6'd62;
        for (int i = 0; i < 4; i++) begin
            tick(4);
            vec++;
            if (obs !== e[i]) begin errs++; $display("FAIL saturate[%0d]: got %h want %h", i, obs, e[i]); end
        end
    endtask

    // Setting mode over frames 4..9: blink 0,1,1,0,0,1.
    task automatic test_blink;
        logic [10:0] e [7];
        int          dt [7];
        e  = '{ev(4'b1000,4'd1,1,1), ev(4'b0000,4'd1,0,1), ev(4'b0000,4'd3,0,1),
               ev(4'b0000,4'd1,0,1), ev(4'b1000,4'd1,1,1), ev(4'b1000,4'd1,1,1),
               ev(4'b0000,4'd1,0,1)};
        dt = '{4, 16, 8, 8, 16, 16, 16};
        stopwatch_mode_en = 1'b0;
        setting_mode_en   = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick(dt[i]);
            vec++;
            if (obs !== e[i]) begin errs++; $display("FAIL blink[%0d]: got %h want %h", i, obs, e[i]); end
        end
    endtask

    // Ringing normal mode blinks (frames 10,11), then alarm mode 07:30 (frames 12,13).
    task automatic test_alarm;
        logic [10:0] e [5];
        int          dt [5];
        e  = '{ev(4'b0000,4'd1,0,0), ev(4'b1000,4'd1,1,0), ev(4'b1000,4'd0,1,2),
               ev(4'b0100,4'd7,1,2), ev(4'b0000,4'd0,0,2)};
        dt = '{16, 16, 16, 4, 12};
        setting_mode_en = 1'b0;
        alarm_sound     = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                normal_mode_en = 1'b0; alarm_mode_en = 1'b1; alarm_sound = 1'b0;
                set_time(2'd0, 4'd7, 3'd3, 4'd0);
            end
            tick(dt[i]);
            vec++;
            if (obs !== e[i]) begin errs++; $display("FAIL alarm[%0d]: got %h want %h", i, obs, e[i]); end
        end
    endtask

    // All enables -> stopwatch (frame 14); drop it -> setting at frame 15 only.
    task automatic test_priority;
        logic [10:0] e [3];
        int          dt [3];
        e  = '{ev(4'b1000,4'd5,1,3), ev(4'b0100,4'd9,1,3), ev(4'b1000,4'd0,1,1)};
        dt = '{16, 4, 12};
        normal_mode_en = 1'b1; setting_mode_en = 1'b1;
        alarm_mode_en  = 1'b1; stopwatch_mode_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(dt[i]);
            if (i == 0) stopwatch_mode_en = 1'b0;
            vec++;
            if (obs !== e[i]) begin errs++; $display("FAIL priority[%0d]: got %h want %h", i, obs, e[i]); end
        end
    endtask

    task automatic test_hold;
        logic [10:0] e;
        normal_mode_en = 1'b0; setting_mode_en = 1'b0;
        alarm_mode_en  = 1'b0; stopwatch_mode_en = 1'b0;
        tick(16);
        e = ev(4'b1000, 4'd0, 1'b1, 2'b01);
        vec++;
        if (obs !== e) begin errs++; $display("FAIL hold: got %h want %h", obs, e); end
    endtask

    // Reset asserted mid-slot idx=2, then scan restarts from the leftmost digit.
    task automatic test_reset_mid;
        logic [10:0] e;
        tick(9);
        rst = 1'b0;
        #2;
        e = ev(4'b0000, 4'd0, 1'b0, 2'b00);
        vec++;
        if (obs !== e) begin errs++; $display("FAIL rst_async: got %h want %h", obs, e); end
        normal_mode_en = 1'b1;
        set_time(2'd1, 4'd2, 3'd3, 4'd4);
        tick(2);
        @(negedge clk);
        rst = 1'b1;
        tick(1);
        e = ev(4'b1000, 4'd1, 1'b1, 2'b00);
        vec++;
        if (obs !== e) begin errs++; $display("FAIL rst_restart0: got %h want %h", obs, e); end
        tick(4);
        e = ev(4'b0100, 4'd2, 1'b1, 2'b00);
        vec++;
        if (obs !== e) begin errs++; $display("FAIL rst_restart1: got %h want %h", obs, e); end
    endtask

    initial begin
        test_reset;
        test_normal;
        test_stopwatch;
        test_saturate;
        test_blink;
        test_alarm;
        test_priority;
        test_hold;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
